// File: rtl/rsh_iter_if.sv
// rsh_iter_if: operand/result handshake bundle for the iterative right shifter
interface rsh_iter_if #(parameter int N = 4);
  logic           in_valid;
  logic           in_ready;
  logic [2**N-1:0] in_data;
  logic [N-1:0]   in_amt;
  logic           in_arith;
  logic           out_valid;
  logic           out_ready;
  logic [2**N-1:0] out_data;
  logic           busy;
  modport master (output in_valid, in_data, in_amt, in_arith, out_ready,
                  input  in_ready, out_valid, out_data, busy);
  modport slave  (input  in_valid, in_data, in_amt, in_arith, out_ready,
                  output in_ready, out_valid, out_data, busy);
endinterface

// File: rtl/rsh_iter.sv
// rsh_iter: handshaked right shifter, one bit per clock, logical or arithmetic
module rsh_iter #(parameter int N = 4) (
  input logic      clk,
  input logic      rst,
  rsh_iter_if.slave s
);
  localparam int W = 2**N;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t         state_q, state_d;
  logic [W-1:0]   work_q, work_d;
  logic [N-1:0]   cnt_q, cnt_d;
  logic           mode_q, mode_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE:
        if (s.in_valid) begin
          state_d = SHIFT;
          work_d  = s.in_data;
          cnt_d   = s.in_amt;
          mode_d  = s.in_arith;
        end
      SHIFT:
        if (cnt_q == '0) state_d = DONE;
        else begin
          // fill replicates the sign bit only in arithmetic mode
          work_d = {mode_q & work_q[W-1], work_q[W-1:1]};
          cnt_d  = cnt_q - 1'b1;
        end
      DONE:
        if (s.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign s.in_ready  = state_q == IDLE;
  assign s.out_valid = state_q == DONE;
  assign s.busy      = state_q != IDLE;
  assign s.out_data  = work_q;
endmodule

// File: tb/tb_rsh_iter.sv
// tb_rsh_iter: directed and random checks of rsh_iter against a shift-operator reference
module tb_rsh_iter;
  localparam int N = 4;
  localparam int W = 2**N;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] q[$];
  rsh_iter_if #(.N(N)) b ();
  rsh_iter #(.N(N)) dut (.clk(clk), .rst(rst), .s(b.slave));
  always #5 clk = ~clk;
  function automatic logic [W-1:0] model(logic [W-1:0] d, logic [N-1:0] a, logic ar);
    return ar ? W'($signed(d) >>> a) : d >> a;
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic start(logic [W-1:0] d, logic [N-1:0] a, logic ar);
    int n = 0;
    b.in_valid = 1'b1; b.in_data = d; b.in_amt = a; b.in_arith = ar;
    while (!b.in_ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_wait", 32'(b.in_ready), 32'd1);
    @(posedge clk); #1;
    q.push_back(model(d, a, ar));
    b.in_valid = 1'b0; b.in_data = ~d; b.in_amt = ~a; b.in_arith = ~ar;
  endtask
  task automatic wait_done(logic [N-1:0] a);
    int n = 0;
    logic [W-1:0] e;
    do begin
      @(posedge clk); #1; n++;
    end while (!b.out_valid && n < 40);
    chk("latency", 32'(n), 32'(a) + 32'd1);
    e = (q.size() != 0) ? q.pop_front() : ~b.out_data;
    chk("out_data", 32'(b.out_data), 32'(e));
  endtask
  task automatic finish_op();
    @(posedge clk); #1;
    chk("back_to_idle", 32'({b.in_ready, b.out_valid}), 32'b10);
  endtask
  initial begin
    logic [W-1:0] held;
    logic seen;
    b.in_valid = 1'b0; b.in_data = '0; b.in_amt = '0; b.in_arith = 1'b0; b.out_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("rst_async", 32'({b.out_valid, b.busy, b.out_data}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", 32'(b.in_ready), 32'd1);
    @(posedge clk); #1;
    start(16'hF0F0, 4'd3, 1'b0); wait_done(4'd3); finish_op();
    start(16'h8000, 4'd15, 1'b1); wait_done(4'd15); finish_op();
    start(16'h8000, 4'd15, 1'b0); wait_done(4'd15); finish_op();
    start(16'h7FFF, 4'd15, 1'b1); wait_done(4'd15); finish_op();
    start(16'hB3C1, 4'd5, 1'b1); wait_done(4'd5); finish_op();
    start(16'hA5A5, 4'd0, 1'b0);
    chk("zero_busy1", 32'(b.busy), 32'd1);
    wait_done(4'd0);
    chk("zero_busy2", 32'(b.busy), 32'd1);
    finish_op();
    chk("zero_busy_end", 32'(b.busy), 32'd0);
    for (int i = 0; i < 200; i++) begin
      start(W'($urandom), 4'd3, 1'b0); wait_done(4'd3); finish_op();
    end
    b.out_ready = 1'b0;
    start(16'h1234, 4'd2, 1'b0);
    wait_done(4'd2);
    held = b.out_data;
    b.in_valid = 1'b1; b.in_data = 16'h8421; b.in_amt = 4'd1; b.in_arith = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold", 32'({b.out_valid, b.in_ready, b.out_data}), 32'({1'b1, 1'b0, held}));
    end
    b.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle", 32'({b.in_ready, b.out_valid, b.busy}), 32'b100);
    @(posedge clk); #1;
    chk("bp_accept", 32'({b.in_ready, b.busy}), 32'b01);
    q.push_back(model(16'h8421, 4'd1, 1'b1));
    b.in_valid = 1'b0;
    wait_done(4'd1); finish_op();
    start(16'hFFFF, 4'd10, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_async", 32'({b.out_valid, b.busy, b.out_data}), 32'd0);
    q.delete();
    @(posedge clk); #1 rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      seen |= b.out_valid;
    end
    chk("abort_no_result", 32'(seen), 32'd0);
    start(16'h0100, 4'd8, 1'b0); wait_done(4'd8); finish_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rsh_iter.md
Name: rsh_iter

Overview:
- Sequential, handshaked right shifter for 2**N-bit words. Shifts one bit position per clock, by a run-time amount, in logical or arithmetic mode.
- Sits directly downstream of the fixed combinational shift stage. It is the general-purpose variable shifter consumed by the datapath when the shift amount is not a constant.
- Valid/ready on both sides; one operation in flight at a time.

Parameters:
- N, 4, word-width exponent; data width W = 2**N (16 by default); shift-amount width N bits (0..W-1).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand valid
- in_ready  output  1  block can accept an operand
- in_data  input  2**N  word to shift
- in_amt  input  N  shift amount, 0..2**N-1
- in_arith  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_data  output  2**N  shifted result
- busy  output  1  high whenever state != IDLE

Behaviour:
- Interface (already decided): one clock, clk. Reset rst is asynchronous and active-high.
- Reset, effective immediately:
  - state=IDLE
  - working register, count, mode and out_data = 0
  - out_valid=0, busy=0
  - in_ready=1 once state is IDLE
- Reset mid-operation aborts the operation. No result is ever presented for it.
- States are IDLE, SHIFT and DONE. All outputs are decoded from registered state/data:
  - in_ready = (state==IDLE)
  - out_valid = (state==DONE)
  - busy = (state!=IDLE)
- IDLE:
  - On in_valid && in_ready at an edge: capture in_data into the working register, in_amt into count, in_arith into mode, then go to SHIFT.
  - Otherwise stay.
- SHIFT, at each edge:
  - If count==0: go to DONE; working register unchanged.
  - Else: working register shifts right by 1, and count decrements.
  - MSB fill is the current MSB when mode=1, else 0.
- DONE:
  - out_data = working register, held stable while out_valid && !out_ready.
  - On out_ready at an edge: go to IDLE.
  - in_ready=0, so in_valid is ignored.
- Latency: out_valid rises exactly in_amt+1 edges after the accepting edge. For amt=0 that is 1 edge.
  - Throughput: at most one operation per in_amt+3 cycles with out_ready held high (accept, amt+1, DONE, IDLE).
- Arithmetic: result = in_data >> in_amt (logical) or sign-extended >>> in_amt (arithmetic), truncated to W bits.
  - Shifting never wraps: bits leaving the LSB are discarded.
- Boundary cases:
  - amt = W-1 yields 0/1 (logical) or all-ones/all-zeros per sign (arithmetic).
  - Inputs are sampled only at the accepting edge. in_data/in_amt changes afterwards have no effect.
  - out_ready asserted outside DONE has no effect.
  - in_valid held during SHIFT/DONE is not consumed. It is accepted on the first edge after return to IDLE.
  - rst asserted in the same cycle as any handshake takes priority; the handshake does not occur.
- No combinational path from inputs to outputs.

Test Plan:
- Reset:
  - rst pulsed mid-cycle -> out_valid=0, busy=0 and out_data=16'h0000 immediately, without a clock edge.
  - After release, in_ready=1.
- Logical shift: in_data=16'hF0F0, amt=3, arith=0 -> out_data=16'h1E1E, out_valid rises 4 edges after accept.
  - Equivalence: 200 random words with amt=3, arith=0 -> out_data == in_data>>3 every time.
- Extremes:
  - in_data=16'h8000, amt=15: arith=1 -> 16'hFFFF; arith=0 -> 16'h0001.
  - in_data=16'h7FFF, amt=15, arith=1 -> 16'h0000.
- Zero amount: in_data=16'hA5A5, amt=0 -> out_data=16'hA5A5, out_valid 1 edge after accept, busy high for exactly 2 cycles with out_ready=1.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and out_data stable, in_ready=0, and a pending in_valid is not taken.
  - Raise out_ready -> IDLE next edge, pending operand accepted on the following edge.
- Abort: amt=10 accepted, rst asserted 4 cycles later -> out_valid never asserts.
  - After release, the next operand (16'h0100, amt=8, arith=0) yields 16'h0001 with correct latency.
